bp_me_cce_mem_cmd_arbiter: RTL and testbench
============================================

Name: bp_me_cce_mem_cmd_arbiter

Overview:
Shares one memory command/response port between num_src_p CCE instances. Outbound mem_cmd messages are granted round-robin, subject to an outstanding-request credit limit. Each granted source id is recorded in order. Inbound mem_resp messages return to the oldest recorded source, because memory responds in order. The block sits between the per-CCE mem_cmd/mem_resp channels and the single memory-side link.

Parameters:
num_src_p, 4, number of CCE sources sharing the memory port (power of 2 not required, >=1)
mem_msg_width_p, 576, width of one bp_cce_mem_msg_s (header+data), passed through untouched
max_outstanding_p, 8, maximum commands issued without a matching response (>=1)

Ports:
clk_i  in  1  clock
reset_n_i  in  1  asynchronous active-low reset
mem_cmd_i  in  num_src_p*mem_msg_width_p  per-source commands, source s at slice s
mem_cmd_v_i  in  num_src_p  per-source command valid
mem_cmd_ready_o  out  num_src_p  per-source ready (ready&valid)
mem_cmd_o  out  mem_msg_width_p  granted command to memory
mem_cmd_v_o  out  1  command valid to memory
mem_cmd_ready_i  in  1  memory ready (ready&valid)
mem_resp_i  in  mem_msg_width_p  response from memory
mem_resp_v_i  in  1  response valid
mem_resp_yumi_o  out  1  response consumed (valid->yumi)
mem_resp_o  out  mem_msg_width_p  response broadcast to all sources
mem_resp_v_o  out  num_src_p  one-hot response valid, owner only
mem_resp_yumi_i  in  num_src_p  per-source response consume
drain_i  in  1  block new grants; outstanding responses still complete
outstanding_o  out  $clog2(max_outstanding_p+1)  current outstanding count
idle_o  out  1  outstanding_o==0
err_o  out  1  sticky: response arrived with no outstanding command

Behaviour:
- Reset, asynchronous on reset_n_i low:
  - rr pointer = 0, outstanding = 0, tag FIFO empty, err_o = 0, idle_o = 1.
  - All valid, ready and yumi outputs are 0 while reset is asserted. Reset mid-transaction drops all tracking.
- can_issue = ~drain_i & (outstanding < max_outstanding_p).
- Grant selection:
  - grant = first s with mem_cmd_v_i[s], searching from rr pointer upward with wrap.
  - Selection is combinational, zero latency: mem_cmd_o = mem_cmd_i[grant]; mem_cmd_v_o = can_issue & |mem_cmd_v_i.
  - mem_cmd_ready_o[s] = can_issue & mem_cmd_ready_i & (s==grant). At most one bit is high.
- Grant is never withdrawn while mem_cmd_v_o=1 and mem_cmd_ready_i=0. The rr pointer only moves on handshake, so the output holds stable.
- On command handshake (mem_cmd_v_o & mem_cmd_ready_i):
  - grant is pushed into the tag FIFO.
  - rr pointer becomes grant+1, wrapping at num_src_p-1 back to 0.
- Response routing:
  - head = tag FIFO head.
  - mem_resp_v_o[head] = mem_resp_v_i & ~fifo_empty; all other bits are 0.
  - mem_resp_yumi_o = mem_resp_v_i & ~fifo_empty & mem_resp_yumi_i[head].
  - On yumi, the FIFO pops.
- Response while the FIFO is empty: not forwarded, yumi stays 0, err_o is set and holds until reset.
- Outstanding counter: +1 on command handshake, -1 on response pop. A simultaneous push and pop leaves it unchanged.
- Full condition: when outstanding==max_outstanding_p, no grant is issued, even if a pop happens in the same cycle. Credit is checked on the registered count.
- drain_i takes effect in the same cycle. It never blocks responses.
- A source that is not valid is skipped with no penalty. A single valid source may issue every cycle.
- Tag FIFO entries are $clog2(num_src_p) bits wide, minimum 1. FIFO depth is max_outstanding_p. Pointers wrap modulo depth.

Decomposition:
- No new package types. The message type is bp_cce_mem_msg_s from bp_me_pkg; this block treats it as opaque bits.
- Local constants: src_id_width = BSG_SAFE_CLOG2(num_src_p), cnt_width.
- One natural sub-module: bp_me_src_tag_fifo. It is a depth-max_outstanding_p, single-clock FIFO with async active-low reset, ready&valid push and valid->yumi pop, and exports its count.
- The round-robin search stays inline.

Test Plan:
- All 4 sources valid continuously, mem_cmd_ready_i=1 → grants in order 0,1,2,3, then stall after 8 issues with outstanding_o=8. Return 8 responses → mem_resp_v_o one-hot 0001,0010,0100,1000,0001,0010,0100,1000 in order.
- Sources 1 and 3 valid, mem_cmd_ready_i low for 5 cycles → mem_cmd_o stays equal to source 1's message with mem_cmd_ready_o=0000 throughout. On ready: source 1 handshakes, then source 3 on the next cycle.
- At outstanding=8, a response pop and a pending source-2 command arrive in the same cycle → no grant that cycle, count becomes 7. Source 2 is granted the next cycle and the count returns to 8.
- mem_resp_v_i=1 with the FIFO empty → mem_resp_v_o=0000, mem_resp_yumi_o=0, err_o rises and stays 1 for the following 10 cycles.
- drain_i=1 with 3 outstanding and source 0 valid → no command issued. Three responses pop, idle_o=1, and source 0 issues the cycle after drain_i drops.
- Assert reset_n_i low mid-stream with 5 outstanding → outputs go to 0 asynchronously, without waiting for a clock edge. After release: outstanding_o=0, idle_o=1, err_o=0, first grant goes to source 0.

Source files
------------

// File: rtl/bp_me_cce_mem_cmd_arbiter_pkg.sv
// Shared helpers for the CCE memory command arbiter.
// Message payloads are opaque to this block, so only sizing helpers live here.
package bp_me_cce_mem_cmd_arbiter_pkg;

  // $clog2 that never collapses to a zero-width field
  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bp_me_src_tag_fifo.sv
// In-order record of granted source ids; head names the owner of the next memory response.
// Push is ready&valid, pop is valid->yumi, and the occupancy doubles as the outstanding count.
module bp_me_src_tag_fifo
  import bp_me_cce_mem_cmd_arbiter_pkg::*;
#(
  parameter int width_p = 2,
  parameter int depth_p = 8,
  localparam int cnt_width = $clog2(depth_p + 1)
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic [width_p-1:0]   data_i,
  input  logic                 v_i,
  output logic                 ready_o,
  output logic [width_p-1:0]   data_o,
  output logic                 v_o,
  input  logic                 yumi_i,
  output logic [cnt_width-1:0] count_o
);

  localparam int ptr_width = safe_clog2(depth_p);
  localparam logic [ptr_width-1:0] last_ptr = ptr_width'(depth_p - 1);
  localparam logic [cnt_width-1:0] depth_c = cnt_width'(depth_p);

  logic [width_p-1:0]   mem [depth_p];
  logic [ptr_width-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [cnt_width-1:0] count_reg;
  logic                 push, pop;

  assign ready_o = (count_reg < depth_c);
  assign v_o     = (count_reg != '0);
  assign data_o  = mem[rd_ptr_reg];
  assign count_o = count_reg;
  assign push    = v_i & ready_o;
  assign pop     = yumi_i & v_o;

  function automatic logic [ptr_width-1:0] next_ptr(input logic [ptr_width-1:0] p);
    return (p == last_ptr) ? '0 : p + 1'b1;
  endfunction

  // Payload storage carries no reset; only the pointers define validity
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr_reg] <= data_i;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= next_ptr(wr_ptr_reg);
      if (pop)  rd_ptr_reg <= next_ptr(rd_ptr_reg);
      unique case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/bp_me_cce_mem_cmd_arbiter.sv
// Round-robin arbiter sharing one memory command/response port among several CCEs.
// Responses come back in issue order, so a tag FIFO of granted ids steers each one home.
module bp_me_cce_mem_cmd_arbiter
  import bp_me_cce_mem_cmd_arbiter_pkg::*;
#(
  parameter int num_src_p         = 4,
  parameter int mem_msg_width_p   = 576,
  parameter int max_outstanding_p = 8,
  localparam int src_id_width = safe_clog2(num_src_p),
  localparam int cnt_width    = $clog2(max_outstanding_p + 1)
) (
  input  logic                                 clk_i,
  input  logic                                 reset_n_i,
  input  logic [num_src_p*mem_msg_width_p-1:0] mem_cmd_i,
  input  logic [num_src_p-1:0]                 mem_cmd_v_i,
  output logic [num_src_p-1:0]                 mem_cmd_ready_o,
  output logic [mem_msg_width_p-1:0]           mem_cmd_o,
  output logic                                 mem_cmd_v_o,
  input  logic                                 mem_cmd_ready_i,
  input  logic [mem_msg_width_p-1:0]           mem_resp_i,
  input  logic                                 mem_resp_v_i,
  output logic                                 mem_resp_yumi_o,
  output logic [mem_msg_width_p-1:0]           mem_resp_o,
  output logic [num_src_p-1:0]                 mem_resp_v_o,
  input  logic [num_src_p-1:0]                 mem_resp_yumi_i,
  input  logic                                 drain_i,
  output logic [cnt_width-1:0]                 outstanding_o,
  output logic                                 idle_o,
  output logic                                 err_o
);

  localparam logic [src_id_width:0]   num_src_c = (src_id_width + 1)'(num_src_p);
  localparam logic [src_id_width-1:0] last_src  = src_id_width'(num_src_p - 1);

  logic [mem_msg_width_p-1:0] cmd_arr [num_src_p];
  logic [src_id_width-1:0]    rr_reg, rr_next, grant, head;
  logic [src_id_width:0]      cand;
  logic                       found, can_issue, cmd_hs, tag_ready, tag_v, resp_route, err_reg;
  logic [cnt_width-1:0]       count;

  for (genvar gi = 0; gi < num_src_p; gi++) begin : g_src
    assign cmd_arr[gi]         = mem_cmd_i[gi*mem_msg_width_p +: mem_msg_width_p];
    assign mem_cmd_ready_o[gi] = can_issue & mem_cmd_ready_i & (grant == src_id_width'(gi));
    assign mem_resp_v_o[gi]    = resp_route & (head == src_id_width'(gi));
  end

  // First valid source at or after the rr pointer, wrapping past the last source
  always_comb begin
    grant = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < num_src_p; i++) begin
      cand = {1'b0, rr_reg} + (src_id_width + 1)'(i);
      if (cand >= num_src_c) cand = cand - num_src_c;
      if (!found && mem_cmd_v_i[cand[src_id_width-1:0]]) begin
        found = 1'b1;
        grant = cand[src_id_width-1:0];
      end
    end
  end

  // Credit is taken from the registered count, so a same-cycle pop never frees a slot early
  assign can_issue   = reset_n_i & ~drain_i & tag_ready;
  assign mem_cmd_v_o = can_issue & (|mem_cmd_v_i);
  assign mem_cmd_o   = cmd_arr[grant];
  assign cmd_hs      = mem_cmd_v_o & mem_cmd_ready_i;

  always_comb begin
    rr_next = rr_reg;
    if (cmd_hs) rr_next = (grant == last_src) ? '0 : grant + 1'b1;
  end

  assign resp_route      = reset_n_i & mem_resp_v_i & tag_v;
  assign mem_resp_yumi_o = resp_route & mem_resp_yumi_i[head];
  assign mem_resp_o      = mem_resp_i;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rr_reg  <= '0;
      err_reg <= 1'b0;
    end else begin
      rr_reg <= rr_next;
      if (mem_resp_v_i & ~tag_v) err_reg <= 1'b1;
    end
  end

  bp_me_src_tag_fifo #(
    .width_p (src_id_width),
    .depth_p (max_outstanding_p)
  ) tag_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .data_i    (grant),
    .v_i       (cmd_hs),
    .ready_o   (tag_ready),
    .data_o    (head),
    .v_o       (tag_v),
    .yumi_i    (mem_resp_yumi_o),
    .count_o   (count)
  );

  assign outstanding_o = count;
  assign idle_o        = (count == '0);
  assign err_o         = err_reg;

endmodule

// File: tb/tb_bp_me_cce_mem_cmd_arbiter.sv
// Directed bench for the CCE memory command arbiter: stimulus queues expected grants and
// response owners, a negedge monitor pops and compares on every handshake.
module tb_bp_me_cce_mem_cmd_arbiter;

  localparam int NS = 4;
  localparam int W  = 16;
  localparam int MO = 8;
  localparam int CW = 4;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [NS*W-1:0] mem_cmd_i;
  logic [NS-1:0]   mem_cmd_v_i;
  logic [NS-1:0]   mem_cmd_ready_o;
  logic [W-1:0]    mem_cmd_o;
  logic            mem_cmd_v_o;
  logic            mem_cmd_ready_i;
  logic [W-1:0]    mem_resp_i;
  logic            mem_resp_v_i;
  logic            mem_resp_yumi_o;
  logic [W-1:0]    mem_resp_o;
  logic [NS-1:0]   mem_resp_v_o;
  logic [NS-1:0]   mem_resp_yumi_i;
  logic            drain_i;
  logic [CW-1:0]   outstanding_o;
  logic            idle_o;
  logic            err_o;

  int n_cmp = 0;
  int n_err = 0;
  int exp_cmd[$];
  int exp_resp[$];

  always #5 clk = ~clk;

  bp_me_cce_mem_cmd_arbiter #(
    .num_src_p         (NS),
    .mem_msg_width_p   (W),
    .max_outstanding_p (MO)
  ) dut (
    .clk_i           (clk),
    .reset_n_i       (reset_n),
    .mem_cmd_i       (mem_cmd_i),
    .mem_cmd_v_i     (mem_cmd_v_i),
    .mem_cmd_ready_o (mem_cmd_ready_o),
    .mem_cmd_o       (mem_cmd_o),
    .mem_cmd_v_o     (mem_cmd_v_o),
    .mem_cmd_ready_i (mem_cmd_ready_i),
    .mem_resp_i      (mem_resp_i),
    .mem_resp_v_i    (mem_resp_v_i),
    .mem_resp_yumi_o (mem_resp_yumi_o),
    .mem_resp_o      (mem_resp_o),
    .mem_resp_v_o    (mem_resp_v_o),
    .mem_resp_yumi_i (mem_resp_yumi_i),
    .drain_i         (drain_i),
    .outstanding_o   (outstanding_o),
    .idle_o          (idle_o),
    .err_o           (err_o)
  );

  function automatic logic [W-1:0] msg(input int s);
    return 16'hA000 + 16'(s) * 16'h0111;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every command handshake and every response pop is matched against the queues
  always @(negedge clk) begin
    int s;
    if (reset_n) begin
      if (mem_cmd_v_o && mem_cmd_ready_i) begin
        if (exp_cmd.size() == 0) chk("cmd_unexpected", 32'(mem_cmd_ready_o), 32'd0);
        else begin
          s = exp_cmd.pop_front();
          chk("cmd_data", 32'(mem_cmd_o), 32'(msg(s)));
          chk("cmd_ready", 32'(mem_cmd_ready_o), 32'd1 << s);
          $display("cmd  grant src %0d data %h", s, mem_cmd_o);
        end
      end
      if (mem_resp_yumi_o) begin
        if (exp_resp.size() == 0) chk("resp_unexpected", 32'(mem_resp_v_o), 32'd0);
        else begin
          s = exp_resp.pop_front();
          chk("resp_owner", 32'(mem_resp_v_o), 32'd1 << s);
          chk("resp_data", 32'(mem_resp_o), 32'h5A5A);
          $display("resp owner src %0d v %b", s, mem_resp_v_o);
        end
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    mem_cmd_v_i = '0;
    mem_cmd_ready_i = 1'b0;
    mem_resp_v_i = 1'b0;
    mem_resp_yumi_i = '0;
    drain_i = 1'b0;
    mem_resp_i = 16'h5A5A;
    for (int s = 0; s < NS; s++) mem_cmd_i[s*W +: W] = msg(s);
    step();
    chk("rst_outstanding", 32'(outstanding_o), 32'd0);
    chk("rst_idle", 32'(idle_o), 32'd1);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_cmd_v", 32'(mem_cmd_v_o), 32'd0);
    step();
    reset_n = 1'b1;

    // All sources valid: rotation 0..3 twice, then credit stall at 8
    mem_cmd_v_i = 4'b1111;
    mem_cmd_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) exp_cmd.push_back(i % NS);
    repeat (10) step();
    chk("full_outstanding", 32'(outstanding_o), 32'd8);
    chk("full_cmd_v", 32'(mem_cmd_v_o), 32'd0);
    mem_cmd_v_i = '0;
    for (int i = 0; i < 8; i++) exp_resp.push_back(i % NS);
    mem_resp_v_i = 1'b1;
    mem_resp_yumi_i = 4'b1111;
    repeat (8) step();
    mem_resp_v_i = 1'b0;
    chk("drained_outstanding", 32'(outstanding_o), 32'd0);
    chk("drained_idle", 32'(idle_o), 32'd1);

    // Back-pressure: grant held on source 1 while memory is not ready
    mem_cmd_v_i = 4'b1010;
    mem_cmd_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_data", 32'(mem_cmd_o), 32'(msg(1)));
      chk("hold_ready", 32'(mem_cmd_ready_o), 32'd0);
      chk("hold_v", 32'(mem_cmd_v_o), 32'd1);
      step();
    end
    mem_cmd_ready_i = 1'b1;
    exp_cmd.push_back(1);
    exp_cmd.push_back(3);
    step();
    mem_cmd_v_i = 4'b1000;
    step();
    mem_cmd_v_i = '0;
    exp_resp.push_back(1);
    exp_resp.push_back(3);
    mem_resp_v_i = 1'b1;
    step();
    step();
    mem_resp_v_i = 1'b0;

    // Full with simultaneous pop: no grant that cycle, source 2 next cycle
    mem_cmd_v_i = 4'b0001;
    for (int i = 0; i < 8; i++) exp_cmd.push_back(0);
    repeat (8) step();
    mem_cmd_v_i = 4'b0100;
    mem_resp_v_i = 1'b1;
    exp_resp.push_back(0);
    exp_cmd.push_back(2);
    @(negedge clk);
    chk("fullpop_cmd_v", 32'(mem_cmd_v_o), 32'd0);
    chk("fullpop_ready", 32'(mem_cmd_ready_o), 32'd0);
    step();
    mem_resp_v_i = 1'b0;
    chk("fullpop_outstanding", 32'(outstanding_o), 32'd7);
    step();
    mem_cmd_v_i = '0;
    chk("refill_outstanding", 32'(outstanding_o), 32'd8);
    for (int i = 0; i < 7; i++) exp_resp.push_back(0);
    exp_resp.push_back(2);
    mem_resp_v_i = 1'b1;
    repeat (8) step();
    mem_resp_v_i = 1'b0;
    chk("empty_outstanding", 32'(outstanding_o), 32'd0);

    // Response with nothing outstanding: dropped, sticky error
    chk("err_before", 32'(err_o), 32'd0);
    mem_resp_v_i = 1'b1;
    @(negedge clk);
    chk("orphan_v", 32'(mem_resp_v_o), 32'd0);
    chk("orphan_yumi", 32'(mem_resp_yumi_o), 32'd0);
    step();
    mem_resp_v_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("err_sticky", 32'(err_o), 32'd1);
      step();
    end

    // Drain: grants blocked, responses still return
    mem_cmd_v_i = 4'b0001;
    for (int i = 0; i < 3; i++) exp_cmd.push_back(0);
    repeat (3) step();
    drain_i = 1'b1;
    chk("drain_outstanding", 32'(outstanding_o), 32'd3);
    @(negedge clk);
    chk("drain_cmd_v", 32'(mem_cmd_v_o), 32'd0);
    chk("drain_ready", 32'(mem_cmd_ready_o), 32'd0);
    step();
    for (int i = 0; i < 3; i++) exp_resp.push_back(0);
    mem_resp_v_i = 1'b1;
    repeat (3) step();
    mem_resp_v_i = 1'b0;
    chk("drain_idle", 32'(idle_o), 32'd1);
    @(negedge clk);
    chk("drain_still_blocked", 32'(mem_cmd_v_o), 32'd0);
    step();
    drain_i = 1'b0;
    exp_cmd.push_back(0);
    step();
    mem_cmd_v_i = '0;

    // Asynchronous reset with 5 outstanding
    mem_cmd_v_i = 4'b0001;
    for (int i = 0; i < 4; i++) exp_cmd.push_back(0);
    repeat (4) step();
    chk("pre_rst_outstanding", 32'(outstanding_o), 32'd5);
    mem_cmd_v_i = 4'b1111;
    mem_resp_v_i = 1'b1;
    #1;
    chk("pre_rst_cmd_v", 32'(mem_cmd_v_o), 32'd1);
    chk("pre_rst_ready", 32'(mem_cmd_ready_o), 32'b0010);
    chk("pre_rst_resp_v", 32'(mem_resp_v_o), 32'b0001);
    chk("pre_rst_yumi", 32'(mem_resp_yumi_o), 32'd1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("async_cmd_v", 32'(mem_cmd_v_o), 32'd0);
    chk("async_ready", 32'(mem_cmd_ready_o), 32'd0);
    chk("async_resp_v", 32'(mem_resp_v_o), 32'd0);
    chk("async_yumi", 32'(mem_resp_yumi_o), 32'd0);
    chk("async_outstanding", 32'(outstanding_o), 32'd0);
    chk("async_idle", 32'(idle_o), 32'd1);
    mem_cmd_v_i = '0;
    mem_resp_v_i = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    chk("post_rst_outstanding", 32'(outstanding_o), 32'd0);
    chk("post_rst_idle", 32'(idle_o), 32'd1);
    chk("post_rst_err", 32'(err_o), 32'd0);
    mem_cmd_v_i = 4'b1111;
    exp_cmd.push_back(0);
    step();
    mem_cmd_v_i = '0;
    mem_cmd_ready_i = 1'b0;
    step();

    chk("cmd_queue_empty", 32'(exp_cmd.size()), 32'd0);
    chk("resp_queue_empty", 32'(exp_resp.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
